// File: rtl/mealy_seq_arbiter_if.sv
// Requester, consumer and shared-FSM pins of mealy_seq_arbiter; MEALY_SEQ_STATE_CAPTURE_EN
// adds the fsm_next_state/res_state pair. slave = arbiter side, master = environment side.
interface mealy_seq_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int LEN   = 8,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]     req;
  logic [N_REQ*LEN-1:0] req_data;
  logic [N_REQ-1:0]     gnt;
  logic                 fsm_rst;
  logic                 fsm_inp;
  logic                 fsm_oup;
  logic                 res_valid;
  logic                 res_ready;
  logic [LEN-1:0]       res_data;
  logic [ID_W-1:0]      res_id;
`ifdef MEALY_SEQ_STATE_CAPTURE_EN
  logic [1:0]           fsm_next_state;
  logic [1:0]           res_state;

  modport slave (
    input  req, req_data, fsm_oup, res_ready, fsm_next_state,
    output gnt, fsm_rst, fsm_inp, res_valid, res_data, res_id, res_state
  );
  modport master (
    output req, req_data, fsm_oup, res_ready, fsm_next_state,
    input  gnt, fsm_rst, fsm_inp, res_valid, res_data, res_id, res_state
  );
`else
  modport slave (
    input  req, req_data, fsm_oup, res_ready,
    output gnt, fsm_rst, fsm_inp, res_valid, res_data, res_id
  );
  modport master (
    output req, req_data, fsm_oup, res_ready,
    input  gnt, fsm_rst, fsm_inp, res_valid, res_data, res_id
  );
`endif
endinterface

// File: rtl/mealy_seq_arbiter.sv
// Round-robin time-shares one bit-serial Mealy FSM; result valid LEN+1 cycles after gnt and
// held until res_ready. MEALY_SEQ_STATE_CAPTURE_EN also returns the FSM state after the last bit.
module mealy_seq_arbiter #(
  parameter int N_REQ = 4,
  parameter int LEN   = 8,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  mealy_seq_arbiter_if.slave bus
);
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN-1:0]   shreg_q, shreg_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             fsm_rst_q, fsm_rst_d;
  logic             fsm_inp_q, fsm_inp_d;
  logic             res_valid_q, res_valid_d;
  logic [LEN-1:0]   res_data_q, res_data_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
`ifdef MEALY_SEQ_STATE_CAPTURE_EN
  logic [1:0]       res_state_q, res_state_d;
`endif

  logic             pick_vld;
  logic [ID_W-1:0]  pick_idx;
  logic             last_bit;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // First active requester at or after ptr, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_vld && bus.req[wrap_add(ptr_q, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(ptr_q, k);
      end
    end
  end

  assign last_bit = (cnt_q == CNT_W'(LEN - 1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    gnt_d       = '0;
    fsm_inp_d   = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
`ifdef MEALY_SEQ_STATE_CAPTURE_EN
    res_state_d = res_state_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          shreg_d         = bus.req_data[int'(pick_idx)*LEN +: LEN];
          res_id_d        = pick_idx;
          gnt_d[pick_idx] = 1'b1;
          ptr_d           = wrap_add(pick_idx, 1);
          state_d         = LOAD;
        end
      end
      // FSM is held in reset here, so it starts the first bit in state P.
      LOAD: begin
        fsm_inp_d = shreg_q[0];
        shreg_d   = shreg_q >> 1;
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        res_data_d[cnt_q] = bus.fsm_oup;
        if (last_bit) begin
          res_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
`ifdef MEALY_SEQ_STATE_CAPTURE_EN
          res_state_d = bus.fsm_next_state;
`endif
        end else begin
          fsm_inp_d = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fsm_rst_d = (state_d == IDLE) || (state_d == LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      gnt_q       <= '0;
      fsm_rst_q   <= 1'b1;
      fsm_inp_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
`ifdef MEALY_SEQ_STATE_CAPTURE_EN
      res_state_q <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      gnt_q       <= gnt_d;
      fsm_rst_q   <= fsm_rst_d;
      fsm_inp_q   <= fsm_inp_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
`ifdef MEALY_SEQ_STATE_CAPTURE_EN
      res_state_q <= res_state_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.fsm_rst   = fsm_rst_q;
  assign bus.fsm_inp   = fsm_inp_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
`ifdef MEALY_SEQ_STATE_CAPTURE_EN
  assign bus.res_state = res_state_q;
`endif

endmodule
